// File: rtl/led_alert_ctrl.sv
// led_alert_ctrl: glitch-qualified LED alert that blinks for a bounded time, then latches a steady alarm until acknowledged.
module led_alert_ctrl #(
  parameter int QUAL_CYCLES  = 4,
  parameter int BLINK_HALF   = 8,
  parameter int ALARM_BLINKS = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led_req,
  input  logic       ack,
  output logic       led_out,
  output logic       alarm,
  output logic       busy,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, BLINK = 2'd2, ALARM = 2'd3} state_t;
  localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(ALARM_BLINKS - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] qual_q, qual_d, phase_q, phase_d, blink_q, blink_d;
  logic             led_q, led_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qual_q  <= '0;
      phase_q <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end
  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    phase_d = phase_q;
    blink_d = blink_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        led_d   = 1'b0;
        qual_d  = led_req ? CNT_W'(1) : '0;
        phase_d = '0;
        blink_d = '0;
        state_d = led_req ? QUAL : IDLE;
      end
      QUAL: begin
        led_d = 1'b0;
        if (!led_req) begin
          state_d = IDLE;
          qual_d  = '0;
        end else if (qual_q == QUAL_LAST) begin
          state_d = BLINK;
          qual_d  = '0;
          phase_d = '0;
          blink_d = '0;
          led_d   = 1'b1;
        end else begin
          qual_d = qual_q + 1'b1;
        end
      end
      BLINK: begin
        // Abort takes priority over any toggle or escalation on the same edge
        if (!led_req || ack) begin
          state_d = IDLE;
          led_d   = 1'b0;
          phase_d = '0;
          blink_d = '0;
        end else if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (!led_q) begin
            led_d = 1'b1;
          end else if (blink_q == BLINK_LAST) begin
            state_d = ALARM;
            blink_d = '0;
          end else begin
            led_d   = 1'b0;
            blink_d = blink_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ALARM: begin
        led_d   = !(ack && !led_req);
        state_d = (ack && !led_req) ? IDLE : ALARM;
        phase_d = '0;
        blink_d = '0;
      end
      default: begin
        state_d = IDLE;
        qual_d  = '0;
        phase_d = '0;
        blink_d = '0;
        led_d   = 1'b0;
      end
    endcase
  end
  assign led_out = led_q;
  assign alarm   = (state_q == ALARM);
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;
endmodule

// File: tb/tb_led_alert_ctrl.sv
// tb_led_alert_ctrl: directed checks of qualification, blink timing, escalation, clear and async reset.
module tb_led_alert_ctrl;
  logic       clk, rst_n, led_req, ack;
  logic       led_out, alarm, busy;
  logic [1:0] state_o;
  int tests = 0;
  int fails = 0;
  led_alert_ctrl #(.QUAL_CYCLES(4), .BLINK_HALF(8), .ALARM_BLINKS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .led_req(led_req), .ack(ack),
    .led_out(led_out), .alarm(alarm), .busy(busy), .state_o(state_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [1:0] st, input logic led);
    chk({tag, ".state"}, 8'(state_o), 8'(st));
    chk({tag, ".led"}, 8'(led_out), 8'(led));
    chk({tag, ".alarm"}, 8'(alarm), 8'(st == 2'd3));
    chk({tag, ".busy"}, 8'(busy), 8'(st != 2'd0));
  endtask
  initial begin
    rst_n = 1'b0; led_req = 1'b1; ack = 1'b0;
    #3;
    chk_all("reset", 2'd0, 1'b0);
    step();
    chk_all("reset_hold", 2'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_all("release_qual", 2'd1, 1'b0);
    led_req = 1'b0;
    step();
    chk_all("qual_drop", 2'd0, 1'b0);
    led_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("glitch_a", 2'd1, 1'b0);
    end
    led_req = 1'b0;
    step();
    chk_all("glitch_low", 2'd0, 1'b0);
    led_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("glitch_b", 2'd1, 1'b0);
    end
    step();
    chk_all("blink_entry", 2'd2, 1'b1);
    for (int k = 1; k <= 56; k++) begin
      step();
      if (k < 56) chk_all("blink_run", 2'd2, ((k / 8) % 2) == 0);
      else chk_all("escalate", 2'd3, 1'b1);
    end
    ack = 1'b1;
    step();
    chk_all("alarm_ack_held", 2'd3, 1'b1);
    ack = 1'b0; led_req = 1'b0;
    step();
    chk_all("alarm_latched", 2'd3, 1'b1);
    ack = 1'b1;
    step();
    chk_all("alarm_clear", 2'd0, 1'b0);
    ack = 1'b0; led_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("requal", 2'd1, 1'b0);
    end
    step();
    chk_all("reblink", 2'd2, 1'b1);
    ack = 1'b1;
    step();
    chk_all("blink_ack", 2'd0, 1'b0);
    step();
    chk_all("idle_ack_ignored", 2'd1, 1'b0);
    ack = 1'b0;
    step();
    chk_all("q2", 2'd1, 1'b0);
    step();
    chk_all("q3", 2'd1, 1'b0);
    step();
    chk_all("blink3", 2'd2, 1'b1);
    led_req = 1'b0;
    step();
    chk_all("blink_drop", 2'd0, 1'b0);
    led_req = 1'b1;
    repeat (4) step();
    repeat (3) step();
    chk_all("pre_reset_blink", 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 2'd0, 1'b0);
    step();
    chk_all("async_reset_hold", 2'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("post_reset_qual", 2'd1, 1'b0);
    end
    step();
    chk_all("post_reset_blink", 2'd2, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all("post_reset_phase", 2'd2, k < 8);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
